store_align_unit: RTL and testbench
===================================

// Module: store_align_unit
// PURPOSE
//  Write-side counterpart of the load extension path: takes a store (sb/sh/sw) from the core,
//  places byte/half/word data on the correct byte lanes and generates byte enables for data memory.
//  Sits between the core's store issue and the data-memory port. Runs a req/ack handshake to memory.
//  Misaligned stores that cross a word boundary are split into two word-aligned beats.
// PARAMETERS
//  ADDR_WIDTH       32  byte-address width; beat-2 address wraps modulo 2^ADDR_WIDTH
//  DATA_WIDTH       32  data width; only 32 is supported, so 4 byte lanes
//  ALLOW_MISALIGNED 1   1: split boundary-crossing stores into two beats; 0: reject them with st_err
// PORTS
//  clk        in   1   clock; all state updates on the rising edge
//  reset      in   1   asynchronous, active-high reset
//  st_valid   in   1   store request from the core
//  st_ready   out  1   unit idle and able to accept a store
//  funct3     in   3   000 sb, 001 sh, 010 sw; any other value is illegal
//  st_addr    in   ADDR_WIDTH  byte address of the store
//  st_data    in   DATA_WIDTH  rs2 value; only the low 8/16/32 bits are used
//  st_done    out  1   one-cycle pulse: the store has fully committed to memory
//  st_err     out  1   one-cycle pulse: illegal funct3, or misaligned with ALLOW_MISALIGNED=0
//  mem_req    out  1   memory write request
//  mem_addr   out  ADDR_WIDTH  word-aligned address, with [1:0] equal to 00
//  mem_wdata  out  DATA_WIDTH  lane-aligned write data
//  mem_be     out  4   byte enables; bit i enables mem_wdata[8i+7:8i]
//  mem_ack    in   1   memory accepted the current beat
// BEHAVIOUR
//  Reset: state=IDLE. st_ready=1. st_done, st_err and mem_req are 0. mem_addr, mem_wdata and mem_be are 0.
//   A reset during any state abandons the pending store; no further beats are issued.
//  States: IDLE, BEAT1, BEAT2. All outputs are registered.
//  Accept: st_valid & st_ready sampled at edge N. The unit latches funct3, st_addr and st_data.
//  At accept, with off = st_addr[1:0] and size mask M = 0001 (sb), 0011 (sh) or 1111 (sw):
//   be8 = M << off             (8 bits)
//   d64 = zero-extended data << (8*off)   (64 bits, data = st_data low 8/16/32 bits)
//   split = |be8[7:4]
//  Illegal funct3: at edge N, st_err=1 for one cycle. State stays IDLE and mem_req is never raised.
//  split with ALLOW_MISALIGNED=0: handled the same way as illegal funct3 (st_err pulse, no access).
//  Otherwise at edge N the unit moves to BEAT1 and drives:
//   mem_req=1, mem_addr = addr with [1:0] cleared, mem_be = be8[3:0], mem_wdata = d64[31:0]
//  Lanes outside mem_be are driven to 0.
//  A beat is held stable (req, addr, be, wdata) until mem_ack=1 is sampled at an edge.
//   mem_ack while mem_req=0 is ignored.
//  BEAT1 acked, split=0: mem_req drops, st_done pulses, state returns to IDLE.
//  BEAT1 acked, split=1: state moves to BEAT2 and the next edge drives:
//   mem_addr = BEAT1 address + 4 (wrapping), mem_be = be8[7:4], mem_wdata = d64[63:32]
//  BEAT2 acked: mem_req drops, st_done pulses, state returns to IDLE.
//  Latency: mem_req is high in the cycle after accept. With mem_ack tied high:
//   one-beat store: st_done is high the cycle after accept+1
//   split store: st_done one cycle later than a one-beat store
//  st_ready=1 only in IDLE. st_ready rises in the same cycle st_done pulses.
//   So a new store may be accepted at the edge where st_done is high.
//  st_done and st_err are never high together.
// TESTING
//  sw addr=0x100, data=0xDEADBEEF, ack same cycle -> 1 beat: addr 0x100, be=1111, wdata=0xDEADBEEF; done 2 cycles after accept
//  sb addr=0x203, data=0x123456AB -> addr 0x200, be=1000, wdata=0xAB000000; single beat
//  sh addr=0x303, data=0xCAFE -> beat1 0x300 be=1000 wdata=0xFE000000; beat2 0x304 be=0001 wdata=0x000000CA
//  sw addr=0xFFFFFFFE, data=0x11223344 -> beat1 0xFFFFFFFC be=1100 wdata=0x33440000; beat2 0x00000000 be=0011 wdata=0x00001122
//  mem_ack held low 5 cycles on beat1 -> outputs stable throughout; reset asserted in BEAT2 -> mem_req=0 at once, no st_done
//  funct3=011 -> st_err pulse, no mem_req; ALLOW_MISALIGNED=0 with sh addr=0x3 -> st_err, no mem_req

Source files
------------

// File: rtl/store_align_unit.sv
// store_align_unit
//   Write-side data alignment for sb/sh/sw stores. A store is accepted from the core, and its
//   data is shifted onto the correct byte lanes with matching byte enables. It is then issued
//   to data memory over a req/ack handshake. A store that crosses a word boundary becomes two
//   word-aligned beats. If ALLOW_MISALIGNED=0, such a store is rejected with st_err instead.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   st_valid/ready    store request handshake from the core (ready only while idle)
//   funct3            000 sb, 001 sh, 010 sw; other encodings raise st_err
//   st_addr, st_data  byte address and rs2 value of the store
//   st_done           one-cycle pulse when the last beat has been acknowledged
//   st_err            one-cycle pulse for a rejected store (no memory access)
//   mem_req/ack       memory write handshake; a beat is held until ack is sampled
//   mem_addr          word-aligned beat address
//   mem_wdata, mem_be lane-aligned write data and byte enables (unused lanes are zero)
module store_align_unit #(
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic                  st_done,
    output logic                  st_err,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack
);

    typedef enum logic [1:0] {StIdle, StBeat1, StBeat2} state_e;

    state_e                state_q;
    logic                  split_q;
    logic [3:0]            hi_be_q;
    logic [DATA_WIDTH-1:0] hi_data_q;

    // Decode of the incoming store, only meaningful while idle
    logic                    legal;
    logic [3:0]              size_mask;
    logic [DATA_WIDTH-1:0]   data_masked;
    logic [7:0]              be8;
    logic [2*DATA_WIDTH-1:0] d64;
    logic                    split;

    always_comb begin
        legal       = 1'b1;
        size_mask   = 4'b0000;
        data_masked = '0;
        case (funct3)
            3'b000: begin
                size_mask   = 4'b0001;
                data_masked = DATA_WIDTH'(st_data[7:0]);
            end
            3'b001: begin
                size_mask   = 4'b0011;
                data_masked = DATA_WIDTH'(st_data[15:0]);
            end
            3'b010: begin
                size_mask   = 4'b1111;
                data_masked = st_data;
            end
            default: legal = 1'b0;
        endcase
        // Shifting into a double-width window keeps the spill-over lanes for the second beat
        be8   = {4'b0000, size_mask} << st_addr[1:0];
        d64   = {{DATA_WIDTH{1'b0}}, data_masked} << {st_addr[1:0], 3'b000};
        split = |be8[7:4];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            st_ready  <= 1'b1;
            st_done   <= 1'b0;
            st_err    <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'b0000;
            split_q   <= 1'b0;
            hi_be_q   <= 4'b0000;
            hi_data_q <= '0;
        end else begin
            st_done <= 1'b0;
            st_err  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (st_valid && st_ready) begin
                        if (!legal || (split && !ALLOW_MISALIGNED)) begin
                            st_err <= 1'b1;
                        end else begin
                            state_q   <= StBeat1;
                            st_ready  <= 1'b0;
                            mem_req   <= 1'b1;
                            mem_addr  <= {st_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_be    <= be8[3:0];
                            mem_wdata <= d64[DATA_WIDTH-1:0];
                            split_q   <= split;
                            hi_be_q   <= be8[7:4];
                            hi_data_q <= d64[2*DATA_WIDTH-1:DATA_WIDTH];
                        end
                    end
                end
                StBeat1: begin
                    if (mem_ack) begin
                        if (split_q) begin
                            // Second beat follows directly; mem_req stays high
                            state_q   <= StBeat2;
                            mem_addr  <= mem_addr + ADDR_WIDTH'(4);
                            mem_be    <= hi_be_q;
                            mem_wdata <= hi_data_q;
                        end else begin
                            state_q   <= StIdle;
                            st_ready  <= 1'b1;
                            st_done   <= 1'b1;
                            mem_req   <= 1'b0;
                            mem_addr  <= '0;
                            mem_be    <= 4'b0000;
                            mem_wdata <= '0;
                        end
                    end
                end
                StBeat2: begin
                    if (mem_ack) begin
                        state_q   <= StIdle;
                        st_ready  <= 1'b1;
                        st_done   <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= '0;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    st_ready <= 1'b1;
                    mem_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_align_unit.sv
module tb_store_align_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        na_valid;
    logic [2:0]  funct3;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        mem_ack;

    logic        st_ready, st_done, st_err, mem_req;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        na_ready, na_done, na_err, na_req;
    logic [31:0] na_addr, na_wdata;
    logic [3:0]  na_be;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    store_align_unit #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .ALLOW_MISALIGNED(1'b1)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .funct3   (funct3),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_done  (st_done),
        .st_err   (st_err),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be   (mem_be),
        .mem_ack  (mem_ack)
    );

    store_align_unit #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .ALLOW_MISALIGNED(1'b0)
    ) u_dut_na (
        .clk      (clk),
        .reset    (reset),
        .st_valid (na_valid),
        .st_ready (na_ready),
        .funct3   (funct3),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_done  (na_done),
        .st_err   (na_err),
        .mem_req  (na_req),
        .mem_addr (na_addr),
        .mem_wdata(na_wdata),
        .mem_be   (na_be),
        .mem_ack  (mem_ack)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata);
        check_eq({tag, " req"},   64'(mem_req),   64'd1);
        check_eq({tag, " addr"},  64'(mem_addr),  64'(addr));
        check_eq({tag, " be"},    64'(mem_be),    64'(be));
        check_eq({tag, " wdata"}, 64'(mem_wdata), 64'(wdata));
        check_eq({tag, " done"},  64'(st_done),   64'd0);
        check_eq({tag, " ready"}, 64'(st_ready),  64'd0);
    endtask

    task automatic check_done(input string tag);
        check_eq({tag, " done"},  64'(st_done),  64'd1);
        check_eq({tag, " err"},   64'(st_err),   64'd0);
        check_eq({tag, " req"},   64'(mem_req),  64'd0);
        check_eq({tag, " ready"}, 64'(st_ready), 64'd1);
    endtask

    // Presents a store for exactly one rising edge; returns at the negedge after acceptance
    task automatic issue(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        funct3   = f3;
        st_addr  = addr;
        st_data  = data;
        st_valid = 1'b1;
        @(negedge clk);
        st_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        st_valid = 1'b0;
        na_valid = 1'b0;
        funct3   = 3'b000;
        st_addr  = '0;
        st_data  = '0;
        mem_ack  = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst ready", 64'(st_ready),  64'd1);
        check_eq("rst req",   64'(mem_req),   64'd0);
        check_eq("rst done",  64'(st_done),   64'd0);
        check_eq("rst err",   64'(st_err),    64'd0);
        check_eq("rst addr",  64'(mem_addr),  64'd0);
        check_eq("rst be",    64'(mem_be),    64'd0);
        check_eq("rst wdata", 64'(mem_wdata), 64'd0);
        reset = 1'b0;

        // Aligned word, acked immediately: done two cycles after accept
        issue(3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        check_beat("sw", 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
        @(negedge clk);
        check_done("sw");

        // Byte at offset 3
        issue(3'b000, 32'h0000_0203, 32'h1234_56AB);
        check_beat("sb", 32'h0000_0200, 4'b1000, 32'hAB00_0000);
        @(negedge clk);
        check_done("sb");

        // Half crossing a word boundary
        issue(3'b001, 32'h0000_0303, 32'h0000_CAFE);
        check_beat("sh b1", 32'h0000_0300, 4'b1000, 32'hFE00_0000);
        @(negedge clk);
        check_beat("sh b2", 32'h0000_0304, 4'b0001, 32'h0000_00CA);
        @(negedge clk);
        check_done("sh");

        // Word crossing the top of the address space
        issue(3'b010, 32'hFFFF_FFFE, 32'h1122_3344);
        check_beat("wrap b1", 32'hFFFF_FFFC, 4'b1100, 32'h3344_0000);
        @(negedge clk);
        check_beat("wrap b2", 32'h0000_0000, 4'b0011, 32'h0000_1122);
        @(negedge clk);
        check_done("wrap");

        // Stall beat 1 for five cycles, then reset during beat 2
        mem_ack = 1'b0;
        issue(3'b001, 32'h0000_0303, 32'h0000_1234);
        for (int i = 0; i < 5; i++) begin
            check_beat("stall b1", 32'h0000_0300, 4'b1000, 32'h3400_0000);
            @(negedge clk);
        end
        check_beat("stall b1 end", 32'h0000_0300, 4'b1000, 32'h3400_0000);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_beat("stall b2", 32'h0000_0304, 4'b0001, 32'h0000_0012);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst beat2 req",   64'(mem_req),  64'd0);
        check_eq("rst beat2 ready", 64'(st_ready), 64'd1);
        check_eq("rst beat2 done",  64'(st_done),  64'd0);
        @(negedge clk);
        reset   = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post rst done", 64'(st_done), 64'd0);
            check_eq("post rst req",  64'(mem_req), 64'd0);
        end

        // Illegal funct3
        issue(3'b011, 32'h0000_0100, 32'h0000_0055);
        check_eq("ill err",   64'(st_err),   64'd1);
        check_eq("ill done",  64'(st_done),  64'd0);
        check_eq("ill req",   64'(mem_req),  64'd0);
        check_eq("ill ready", 64'(st_ready), 64'd1);
        @(negedge clk);
        check_eq("ill err pulse", 64'(st_err),  64'd0);
        check_eq("ill req after", 64'(mem_req), 64'd0);

        // Misaligned half rejected when splitting is disabled
        @(negedge clk);
        funct3   = 3'b001;
        st_addr  = 32'h0000_0003;
        st_data  = 32'h0000_BEEF;
        na_valid = 1'b1;
        @(negedge clk);
        na_valid = 1'b0;
        check_eq("na err",   64'(na_err),   64'd1);
        check_eq("na req",   64'(na_req),   64'd0);
        check_eq("na done",  64'(na_done),  64'd0);
        @(negedge clk);
        check_eq("na err pulse", 64'(na_err), 64'd0);
        check_eq("na req after", 64'(na_req), 64'd0);

        // Same unit still performs a non-crossing half
        @(negedge clk);
        funct3   = 3'b001;
        st_addr  = 32'h0000_0042;
        st_data  = 32'hFFFF_5AA5;
        na_valid = 1'b1;
        @(negedge clk);
        na_valid = 1'b0;
        check_eq("na ok req",   64'(na_req),   64'd1);
        check_eq("na ok addr",  64'(na_addr),  64'h40);
        check_eq("na ok be",    64'(na_be),    64'b1100);
        check_eq("na ok wdata", 64'(na_wdata), 64'h5AA5_0000);
        @(negedge clk);
        check_eq("na ok done",  64'(na_done),  64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
